ring_router_arbiter: RTL and testbench



---
 rtl/ring_router_arbiter.sv | 102 ++++++++++
 tb/tb_ring_router_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_arbiter.sv
// rtl/ring_router_arbiter.sv - worm-locked round-robin merge of dii_flit sources onto one ring link
package dii_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;
endpackage

module ring_router_arbiter
  import dii_pkg::*;
#(
  parameter int N       = 2,
  parameter int GRANT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  dii_flit [N-1:0]     in_flit,
  output logic    [N-1:0]     in_ready,
  output dii_flit             out_flit,
  input  logic                out_ready,
  output logic [GRANT_W-1:0]  grant_idx,
  output logic                busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_t;

  localparam logic [GRANT_W:0] N_W = (GRANT_W+1)'(N);

  lock_t              lock;
  logic [GRANT_W-1:0] lock_idx;
  logic [GRANT_W-1:0] rr_ptr;
  logic [GRANT_W-1:0] sel;
  logic [N-1:0]       req;

  // Pointer increment that wraps at N, so non-power-of-2 N never lands on an unused index.
  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] x);
    logic [GRANT_W:0] s;
    s = {1'b0, x} + (GRANT_W+1)'(1);
    if (s == N_W) s = '0;
    return s[GRANT_W-1:0];
  endfunction

  // Gather the per-input valid bits into one request vector.
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) req[i] = in_flit[i].valid;
  end

  // Pick the source: the locked worm owner, else the first requester at or after rr_ptr.
  always_comb begin
    logic [GRANT_W:0] cand;
    logic             found;
    cand  = '0;
    found = 1'b0;
    sel   = rr_ptr;
    if (lock == LOCKED) begin
      sel = lock_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = {1'b0, rr_ptr} + (GRANT_W+1)'(k);
        if (cand >= N_W) cand = cand - N_W;
        if (!found && req[cand[GRANT_W-1:0]]) begin
          sel   = cand[GRANT_W-1:0];
          found = 1'b1;
        end
      end
    end
  end

  // Zero-latency steering: the selected flit goes straight out, only its source sees ready.
  always_comb begin
    out_flit      = in_flit[sel];
    in_ready      = '0;
    in_ready[sel] = out_ready;
  end

  assign grant_idx = sel;
  assign busy      = (lock == LOCKED);

  // Lock on a worm's first flit, release and advance the pointer only when a packet ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock     <= IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else if (out_flit.valid && out_ready) begin
      if (lock == IDLE) begin
        if (out_flit.last) begin
          rr_ptr <= wrap_inc(sel);
        end else begin
          lock     <= LOCKED;
          lock_idx <= sel;
        end
      end else if (out_flit.last) begin
        lock   <= IDLE;
        rr_ptr <= wrap_inc(lock_idx);
      end
    end
  end

endmodule

// File: tb/tb_ring_router_arbiter.sv
// tb/tb_ring_router_arbiter.sv - randomized and directed bench for ring_router_arbiter (N=2 and N=3)
module tb_ring_router_arbiter;
  import dii_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  dii_flit [1:0] in2;
  dii_flit [2:0] in3;
  logic [1:0]    rdy2;
  logic [2:0]    rdy3;
  dii_flit       o2, o3;
  logic          or2, or3;
  logic [0:0]    g2;
  logic [1:0]    g3;
  logic          b2, b3;

  int compared   = 0;
  int mismatched = 0;

  // stimulus generator state, index [dut][input]; dut 0 has N=2, dut 1 has N=3
  int fix_len [2][3];
  int vprob   [2][3];
  int rprob   [2];
  int cur_len [2][3];
  int cur_f   [2][3];
  int pkt     [2][3];
  // reference model: owner of the packet in flight (-1 none) and whose turn is next
  int m_owner [2];
  int m_turn  [2];
  // output-stream scoreboard
  int sb_open [2];
  int sb_src  [2];
  int sb_f    [2];

  ring_router_arbiter #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .in_flit(in2), .in_ready(rdy2),
    .out_flit(o2), .out_ready(or2), .grant_idx(g2), .busy(b2));

  ring_router_arbiter #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .in_flit(in3), .in_ready(rdy3),
    .out_flit(o3), .out_ready(or3), .grant_idx(g3), .busy(b3));

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_models();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_turn[d]  = 0;
      sb_open[d] = 0;
      for (int i = 0; i < 3; i++) cur_f[d][i] = 0;
    end
  endtask

  task automatic drive();
    dii_flit fl;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ((d == 0) ? 2 : 3); i++) begin
        if (cur_f[d][i] == 0)
          cur_len[d][i] = (fix_len[d][i] > 0) ? fix_len[d][i] : int'($urandom_range(4, 1));
        fl.data  = {4'(i), 8'(pkt[d][i]), 4'(cur_f[d][i])};
        fl.last  = (cur_f[d][i] == cur_len[d][i] - 1);
        fl.valid = ($urandom_range(99) < vprob[d][i]);
        if (d == 0) in2[i] = fl;
        else        in3[i] = fl;
      end
    end
    or2 = ($urandom_range(99) < rprob[0]);
    or3 = ($urandom_range(99) < rprob[1]);
  endtask

  task automatic check(input int d);
    int         n, sel, c, og;
    logic [2:0] v, l, ordy, erdy;
    logic [47:0] dat;
    dii_flit    obs, e;
    logic       rdy, ob;
    string      p;
    n = (d == 0) ? 2 : 3;
    p = (d == 0) ? "n2" : "n3";
    v = '0; l = '0; dat = '0;
    for (int i = 0; i < n; i++) begin
      if (d == 0) begin
        v[i] = in2[i].valid; l[i] = in2[i].last; dat[i*16 +: 16] = in2[i].data;
      end else begin
        v[i] = in3[i].valid; l[i] = in3[i].last; dat[i*16 +: 16] = in3[i].data;
      end
    end
    if (d == 0) begin
      obs = o2; ordy = {1'b0, rdy2}; og = int'(g2); ob = b2; rdy = or2;
    end else begin
      obs = o3; ordy = rdy3; og = int'(g3); ob = b3; rdy = or3;
    end
    if (m_owner[d] >= 0) begin
      sel = m_owner[d];
    end else begin
      sel = m_turn[d];
      for (int k = n - 1; k >= 0; k--) begin
        c = (m_turn[d] + k) % n;
        if (v[c]) sel = c;
      end
    end
    e.data  = dat[sel*16 +: 16];
    e.last  = l[sel];
    e.valid = v[sel];
    erdy = '0;
    erdy[sel] = rdy;
    cmp({p, " out_flit"}, obs, e);
    cmp({p, " in_ready"}, ordy, erdy);
    cmp({p, " grant_idx"}, og, sel);
    cmp({p, " busy"}, ob, m_owner[d] >= 0);
    if (e.valid && rdy) begin
      if (sb_open[d] != 0)
        cmp({p, " worm_contig"}, {obs.data[15:12], obs.data[3:0]}, {4'(sb_src[d]), 4'(sb_f[d] + 1)});
      else
        cmp({p, " pkt_start"}, obs.data[3:0], 0);
      sb_open[d] = obs.last ? 0 : 1;
      sb_src[d]  = int'(obs.data[15:12]);
      sb_f[d]    = int'(obs.data[3:0]);
      cur_f[d][sel]++;
      if (e.last) begin
        cur_f[d][sel] = 0;
        pkt[d][sel]++;
      end
      if (m_owner[d] < 0) begin
        if (!e.last) m_owner[d] = sel;
        else         m_turn[d]  = (sel + 1) % n;
      end else if (e.last) begin
        m_owner[d] = -1;
        m_turn[d]  = (sel + 1) % n;
      end
    end
  endtask

  task automatic pre();
    drive();
    #1;
  endtask

  task automatic post();
    check(0);
    check(1);
    @(negedge clk);
  endtask

  task automatic drain(input int d);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 3; i++) vprob[d][i] = 100;
    rprob[d] = 100;
    while (m_owner[d] >= 0 && cnt < 40) begin
      pre(); post();
      cnt++;
    end
    cmp($sformatf("drain%0d_timeout", d), m_owner[d], -1);
  endtask

  initial begin
    rst = 1'b1;
    in2 = '0; in3 = '0; or2 = 1'b1; or3 = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rprob[d] = 100;
      for (int i = 0; i < 3; i++) begin
        fix_len[d][i] = 0; vprob[d][i] = 0; cur_len[d][i] = 1; pkt[d][i] = 0;
      end
    end
    reset_models();
    @(negedge clk);
    @(negedge clk);
    cmp("rst n2 busy", b2, 0);
    cmp("rst n2 grant", g2, 0);
    cmp("rst n2 out_valid", o2.valid, 0);
    cmp("rst n2 in_ready", rdy2, 2'b01);
    cmp("rst n3 busy", b3, 0);
    cmp("rst n3 grant", g3, 0);
    cmp("rst n3 out_valid", o3.valid, 0);
    cmp("rst n3 in_ready", rdy3, 3'b001);
    rst = 1'b0;

    // N=2 single-flit alternation alongside N=3 two-flit round robin with wrap
    for (int i = 0; i < 3; i++) begin
      fix_len[0][i] = 1; vprob[0][i] = 100;
      fix_len[1][i] = 2; vprob[1][i] = 100;
    end
    for (int c = 0; c < 12; c++) begin
      pre();
      cmp("t1 n2 grant", g2, c % 2);
      cmp("t1 n2 busy", b2, 0);
      cmp("t5 n3 grant", g3, (c / 2) % 3);
      cmp("t5 n3 busy", b3, c % 2);
      post();
    end

    // randomized traffic on both instances
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) fix_len[d][i] = 0;
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 0) begin
        for (int d = 0; d < 2; d++) begin
          rprob[d] = $urandom_range(95, 40);
          for (int i = 0; i < 3; i++) vprob[d][i] = $urandom_range(95, 20);
        end
      end
      pre(); post();
    end

    // 4-flit worm on input0, input1 valid from cycle 1
    drain(0);
    fix_len[0][0] = 4; fix_len[0][1] = 1; vprob[0][1] = 0;
    for (int c = 0; c < 5; c++) begin
      pre();
      cmp("t2 grant", g2, (c < 4) ? 0 : 1);
      cmp("t2 busy", b2, (c >= 1 && c <= 3) ? 1 : 0);
      post();
      vprob[0][1] = 100;
    end

    // locked on input1, input1 stalls 3 cycles while input0 waits
    drain(0);
    fix_len[0][1] = 4; vprob[0][0] = 0;
    pre(); post();
    vprob[0][0] = 100; vprob[0][1] = 0;
    for (int c = 0; c < 3; c++) begin
      pre();
      cmp("t3 out_valid", o2.valid, 0);
      cmp("t3 in_ready0", rdy2[0], 0);
      cmp("t3 busy", b2, 1);
      post();
    end
    vprob[0][1] = 100;
    for (int c = 0; c < 3; c++) begin
      pre();
      cmp("t3 resume grant", g2, 1);
      cmp("t3 resume valid", o2.valid, 1);
      post();
    end

    // out_ready low for 5 cycles inside a worm on input0
    drain(0);
    fix_len[0][0] = 4; vprob[0][1] = 0;
    pre(); post();
    rprob[0] = 0;
    for (int c = 0; c < 5; c++) begin
      pre();
      cmp("t4 stall busy", b2, 1);
      cmp("t4 stall flit", o2.data[3:0], 1);
      post();
    end
    rprob[0] = 100;
    for (int c = 0; c < 3; c++) begin
      pre();
      cmp("t4 seq flit", o2.data[3:0], c + 1);
      post();
    end

    // asynchronous reset mid-worm on input1
    drain(0);
    fix_len[0][1] = 4; vprob[0][0] = 0; vprob[0][1] = 100;
    pre(); post();
    pre(); post();
    vprob[0][0] = 100;
    pre();
    cmp("t6 pre busy", b2, 1);
    cmp("t6 pre grant", g2, 1);
    post();
    #2;
    rst = 1'b1;
    #1;
    cmp("t6 async busy", b2, 0);
    cmp("t6 async grant", g2, 0);
    reset_models();
    @(negedge clk);
    rst = 1'b0;
    pre();
    cmp("t6 first grant", g2, 0);
    cmp("t6 first valid", o2.valid, 1);
    post();
    for (int c = 0; c < 20; c++) begin
      pre(); post();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
